memoria_dados: RTL and testbench

//   Data memory of the Redux-V datapath: 256 x 8-bit RAM addressed by the ALU/register result.

---
 rtl/memoria_pkg.sv | 11 +
 rtl/memoria_dados_if.sv | 24 ++
 rtl/memoria_dados.sv | 26 ++
 tb/tb_memoria_dados.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/memoria_pkg.sv
// Shared memory geometry for the Redux-V datapath: word/address widths and derived types.
package memoria_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/memoria_dados_if.sv
// Single-port data-memory bus: write strobe, address, write data and combinational read data.
interface memoria_dados_if;
  import memoria_pkg::*;

  logic  writeEnable;
  addr_t endereco;
  data_t dadoEntrada;
  data_t dadoSaida;

  modport master (
    output writeEnable,
    output endereco,
    output dadoEntrada,
    input  dadoSaida
  );

  modport slave (
    input  writeEnable,
    input  endereco,
    input  dadoEntrada,
    output dadoSaida
  );

endinterface

// File: rtl/memoria_dados.sv
// Redux-V data memory: DEPTH x DATA_W RAM, synchronous write, asynchronous read,
// whole array cleared by an asynchronous active-high reset.
module memoria_dados
  import memoria_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  memoria_dados_if.slave  bus
);

  data_t mem_q [DEPTH];

  // Reset dominates any write on the same edge; an X strobe falls into the no-write branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[addr_t'(i)] <= '0;
      end
    end else if (bus.writeEnable) begin
      mem_q[bus.endereco] <= bus.dadoEntrada;
    end
  end

  assign bus.dadoSaida = mem_q[bus.endereco];

endmodule

// File: tb/tb_memoria_dados.sv
// Self-checking bench for memoria_dados against an array model of the RAM.
module tb_memoria_dados;
  import memoria_pkg::*;

  logic clk;
  logic rst;
  memoria_dados_if bus ();

  memoria_dados dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] model [256];
  int errors = 0;
  int checks = 0;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_read(input string name, input logic [7:0] addr, input logic [7:0] exp);
    bus.endereco = addr;
    #1;
    checks++;
    if (bus.dadoSaida !== exp) begin
      errors++;
      $display("FAIL %s addr=%02h got=%02h expected=%02h", name, addr, bus.dadoSaida, exp);
    end
  endtask

  // Drives one write; old value must be visible before the edge, new value right after.
  task automatic write_word(input string name, input logic [7:0] addr, input logic [7:0] data);
    bus.writeEnable = 1'b1;
    bus.endereco    = addr;
    bus.dadoEntrada = data;
    #1;
    checks++;
    if (bus.dadoSaida !== model[addr]) begin
      errors++;
      $display("FAIL %s_pre addr=%02h got=%02h expected=%02h", name, addr, bus.dadoSaida,
               model[addr]);
    end
    tick();
    model[addr] = data;
    bus.writeEnable = 1'b0;
    checks++;
    if (bus.dadoSaida !== model[addr]) begin
      errors++;
      $display("FAIL %s_post addr=%02h got=%02h expected=%02h", name, addr, bus.dadoSaida,
               model[addr]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    check_read("reset_0f", 8'h0F, 8'h00);
    check_read("reset_f0", 8'hF0, 8'h00);
    check_read("reset_ff", 8'hFF, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_basic();
    write_word("write1", 8'h0F, 8'hF0);
    write_word("write2", 8'hF0, 8'h0F);
    check_read("write2_keep_0f", 8'h0F, 8'hF0);
  endtask

  task automatic test_readback();
    bus.writeEnable = 1'b0;
    bus.dadoEntrada = 8'hAA;
    check_read("rb_0f", 8'h0F, model[8'h0F]);
    tick();
    check_read("rb_0f_edge", 8'h0F, model[8'h0F]);
    check_read("rb_f0", 8'hF0, model[8'hF0]);
    tick();
    tick();
    check_read("rb_f0_edge", 8'hF0, model[8'hF0]);
  endtask

  task automatic test_boundaries();
    write_word("bnd_00", 8'h00, 8'h5A);
    write_word("bnd_ff", 8'hFF, 8'hA5);
    check_read("bnd_rd_00", 8'h00, 8'h5A);
    check_read("bnd_rd_ff", 8'hFF, 8'hA5);
    check_read("bnd_nb_01", 8'h01, 8'h00);
    check_read("bnd_nb_fe", 8'hFE, 8'h00);
  endtask

  task automatic test_random();
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      addr = 8'($urandom);
      data = 8'($urandom);
      bus.writeEnable = we;
      bus.endereco    = addr;
      bus.dadoEntrada = data;
      #1;
      checks++;
      if (bus.dadoSaida !== model[addr]) begin
        errors++;
        $display("FAIL rnd_pre n=%0d addr=%02h got=%02h expected=%02h", n, addr,
                 bus.dadoSaida, model[addr]);
      end
      tick();
      if (we) model[addr] = data;
      checks++;
      if (bus.dadoSaida !== model[addr]) begin
        errors++;
        $display("FAIL rnd_post n=%0d addr=%02h got=%02h expected=%02h", n, addr,
                 bus.dadoSaida, model[addr]);
      end
    end
    bus.writeEnable = 1'b0;
    for (int n = 0; n < 64; n++) begin
      addr = 8'($urandom);
      check_read("rnd_sweep", addr, model[addr]);
    end
  endtask

  task automatic test_async_reset();
    write_word("ar_setup", 8'h0F, 8'h3C);
    write_word("ar_setup2", 8'h20, 8'h99);
    bus.endereco = 8'h0F;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (bus.dadoSaida !== 8'h00) begin
      errors++;
      $display("FAIL ar_noclk got=%02h expected=00", bus.dadoSaida);
    end
    bus.writeEnable = 1'b1;
    bus.endereco    = 8'h20;
    bus.dadoEntrada = 8'h77;
    tick();
    bus.writeEnable = 1'b0;
    check_read("ar_write_during_rst", 8'h20, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check_read("ar_after_rel_20", 8'h20, 8'h00);
    check_read("ar_after_rel_0f", 8'h0F, 8'h00);
    write_word("ar_first_write", 8'h20, 8'hC3);
  endtask

  initial begin
    rst = 1'b0;
    bus.writeEnable = 1'b0;
    bus.endereco    = 8'h00;
    bus.dadoEntrada = 8'h00;
    #2;
    test_reset();
    test_write_basic();
    test_readback();
    test_boundaries();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
